// File: rtl/keypad_scanner.sv
// 3x3 keypad matrix scanner: walks an active-low column strobe and samples the rows.
// A press is debounced and reported as a key index with a one-cycle strobe and a held level.
module keypad_scanner #(
  parameter int SCAN_CYCLES = 4,
  parameter int DEBOUNCE    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] row,
  output logic [2:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = ($clog2(SCAN_CYCLES) > 1) ? $clog2(SCAN_CYCLES) : 1;
  // Press/release counters must be able to hold the value DEBOUNCE itself.
  localparam int SW = ($clog2(DEBOUNCE + 1) > 1) ? $clog2(DEBOUNCE + 1) : 1;

  localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [SW-1:0] rel_q, rel_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [2:0]    col_d;
  logic [3:0]    key_code_d;
  logic          key_valid_d;
  logic          key_held_d;

  logic [1:0]    low_idx;
  logic [1:0]    col_next;
  logic          row_bit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    low_idx = 2'd0;
    if (!row[0])      low_idx = 2'd0;
    else if (!row[1]) low_idx = 2'd1;
    else if (!row[2]) low_idx = 2'd2;
  end

  assign col_next = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
  assign row_bit  = row[row_idx_q];

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    stable_d    = stable_q;
    rel_d       = rel_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    key_code_d  = key_code;
    key_valid_d = 1'b0;
    key_held_d  = key_held;

    case (state_q)
      S_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (row == 3'b111) begin
            col_idx_d = col_next;
          end else begin
            row_idx_d = low_idx;
            stable_d  = SW'(1);
            state_d   = S_DEBOUNCE;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      S_DEBOUNCE: begin
        if (!row_bit) begin
          if (stable_q >= STABLE_LAST) begin
            state_d     = S_HELD;
            key_code_d  = 4'(col_idx_q) * 4'd3 + 4'(row_idx_q);
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            rel_d       = '0;
          end else begin
            stable_d = stable_q + SW'(1);
          end
        end else begin
          // Bounce: rescan the same column from a fresh dwell.
          state_d  = S_SCAN;
          dwell_d  = '0;
          stable_d = '0;
        end
      end

      S_HELD: begin
        if (row_bit) begin
          if (rel_q >= STABLE_LAST) begin
            state_d    = S_SCAN;
            key_held_d = 1'b0;
            col_idx_d  = col_next;
            dwell_d    = '0;
            stable_d   = '0;
            rel_d      = '0;
          end else begin
            rel_d = rel_q + SW'(1);
          end
        end else begin
          rel_d = '0;
        end
      end

      default: state_d = S_SCAN;
    endcase
  end

  assign col_d = ~(3'b001 << col_idx_d);

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_SCAN;
      dwell_q   <= '0;
      stable_q  <= '0;
      rel_q     <= '0;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      col       <= 3'b110;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      stable_q  <= stable_d;
      rel_q     <= rel_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      col       <= col_d;
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      key_held  <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a combinational key-matrix model drives the rows,
// a scoreboard queue matches every key_valid strobe to an expected key code.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] row;
  logic [2:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [8:0] pressed;
  logic [3:0] exp_q[$];
  logic       prev_valid;
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  // Key k = col*3 + row pulls its row low while its column is driven low.
  assign row[0] = ~((~col[0] & pressed[0]) | (~col[1] & pressed[3]) | (~col[2] & pressed[6]));
  assign row[1] = ~((~col[0] & pressed[1]) | (~col[1] & pressed[4]) | (~col[2] & pressed[7]));
  assign row[2] = ~((~col[0] & pressed[2]) | (~col[1] & pressed[5]) | (~col[2] & pressed[8]));

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Scoreboard: each strobe must match the oldest pending press and never repeat back to back.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (key_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_key_valid: got strobe with key_code=%0d, expected no strobe", key_code);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (key_code !== e)
            $display("FAIL scoreboard_key_code: got %0d, expected %0d", key_code, e);
          else
            passed++;
        end
        checks++;
        if (prev_valid === 1'b1)
          $display("FAIL valid_back_to_back: got key_valid high two cycles, expected one");
        else
          passed++;
      end
      prev_valid = key_valid;
    end
  end

  task automatic wait_col_enter(input logic [2:0] c);
    logic [2:0] prev;
    prev = col;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (col === c && prev !== c) return;
      prev = col;
    end
    checks++;
    $display("FAIL wait_col_timeout: got col=%b, expected entry into col=%b", col, c);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    pressed = 9'd0;
    repeat (2) @(negedge clk);
    checks++; if (col !== 3'b110) $display("FAIL reset_col: got %b, expected 110", col); else passed++;
    checks++; if (key_code !== 4'd0) $display("FAIL reset_key_code: got %0d, expected 0", key_code); else passed++;
    checks++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b, expected 0", key_valid); else passed++;
    checks++; if (key_held !== 1'b0) $display("FAIL reset_key_held: got %b, expected 0", key_held); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_idle_sweep();
    logic [2:0] col_tab [3];
    logic [2:0] exp_col;
    col_tab = '{3'b110, 3'b101, 3'b011};
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_col = col_tab[(i / 4) % 3];
      checks++;
      if (col !== exp_col || key_valid !== 1'b0 || key_held !== 1'b0)
        $display("FAIL idle_sweep_%0d: got col=%b valid=%b held=%b, expected col=%b valid=0 held=0",
                 i, col, key_valid, key_held, exp_col);
      else
        passed++;
    end
  endtask

  task automatic test_clean_press();
    wait_col_enter(3'b101);
    pressed[5] = 1'b1;
    exp_q.push_back(4'd5);
    repeat (4) @(negedge clk);  // dwell, then first low sample
    @(negedge clk);
    checks++; if (key_valid !== 1'b0) $display("FAIL press_early_1: got valid=%b, expected 0", key_valid); else passed++;
    @(negedge clk);
    checks++; if (key_valid !== 1'b1) $display("FAIL press_latency: got valid=%b, expected 1", key_valid); else passed++;
    checks++; if (key_held !== 1'b1) $display("FAIL press_held: got held=%b, expected 1", key_held); else passed++;
    @(negedge clk);
    checks++; if (key_valid !== 1'b0) $display("FAIL press_pulse_width: got valid=%b, expected 0", key_valid); else passed++;
    repeat (14) @(negedge clk);
    checks++; if (key_held !== 1'b1) $display("FAIL hold_level: got held=%b, expected 1", key_held); else passed++;
    checks++; if (col !== 3'b101) $display("FAIL hold_col: got col=%b, expected 101", col); else passed++;
    checks++; if (key_code !== 4'd5) $display("FAIL hold_code: got %0d, expected 5", key_code); else passed++;
  endtask

  task automatic test_release();
    pressed[5] = 1'b0;
    @(negedge clk);
    checks++; if (key_held !== 1'b1) $display("FAIL release_early_1: got held=%b, expected 1", key_held); else passed++;
    @(negedge clk);
    checks++; if (key_held !== 1'b1) $display("FAIL release_early_2: got held=%b, expected 1", key_held); else passed++;
    @(negedge clk);
    checks++; if (key_held !== 1'b0) $display("FAIL release_held: got held=%b, expected 0", key_held); else passed++;
    checks++; if (col !== 3'b011) $display("FAIL release_col: got col=%b, expected 011", col); else passed++;
    checks++; if (key_code !== 4'd5) $display("FAIL release_code: got %0d, expected 5", key_code); else passed++;
  endtask

  task automatic test_press_bounce();
    wait_col_enter(3'b110);
    repeat (3) @(negedge clk);
    pressed[0] = 1'b1;
    repeat (2) @(negedge clk);  // two low samples, one short of acceptance
    pressed[0] = 1'b0;
    @(negedge clk);
    checks++; if (col !== 3'b110) $display("FAIL bounce_col: got col=%b, expected 110", col); else passed++;
    checks++;
    if (key_valid !== 1'b0 || key_held !== 1'b0)
      $display("FAIL bounce_no_press: got valid=%b held=%b, expected 0 0", key_valid, key_held);
    else
      passed++;
    repeat (3) @(negedge clk);
    checks++; if (col !== 3'b110) $display("FAIL bounce_dwell_restart: got col=%b, expected 110", col); else passed++;
    @(negedge clk);
    checks++; if (col !== 3'b101) $display("FAIL bounce_advance: got col=%b, expected 101", col); else passed++;
  endtask

  task automatic test_priority_glitch();
    wait_col_enter(3'b011);
    pressed[6] = 1'b1;
    pressed[7] = 1'b1;
    exp_q.push_back(4'd6);
    repeat (6) @(negedge clk);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd6)
      $display("FAIL priority_press: got valid=%b code=%0d, expected valid=1 code=6", key_valid, key_code);
    else
      passed++;
    repeat (3) @(negedge clk);
    pressed[6] = 1'b0;
    @(negedge clk);
    pressed[6] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (key_held !== 1'b1 || col !== 3'b011)
        $display("FAIL hold_glitch_%0d: got held=%b col=%b, expected held=1 col=011", i, key_held, col);
      else
        passed++;
    end
  endtask

  task automatic test_reset_mid_hold();
    checks++; if (key_held !== 1'b1) $display("FAIL pre_reset_held: got held=%b, expected 1", key_held); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (col !== 3'b110) $display("FAIL midhold_reset_col: got %b, expected 110", col); else passed++;
    checks++; if (key_code !== 4'd0) $display("FAIL midhold_reset_code: got %0d, expected 0", key_code); else passed++;
    checks++; if (key_valid !== 1'b0) $display("FAIL midhold_reset_valid: got %b, expected 0", key_valid); else passed++;
    checks++; if (key_held !== 1'b0) $display("FAIL midhold_reset_held: got %b, expected 0", key_held); else passed++;
    pressed = 9'd0;
    reset   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending presses, expected 0", exp_q.size());
    else
      passed++;
  endtask

  initial begin
    test_reset();
    test_idle_sweep();
    test_clean_press();
    test_release();
    test_press_bounce();
    test_priority_glitch();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
